// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the RV64I core.
// Holds the IF/ID bundle, fetch FSM states and fetch constants.
package pipeline_pkg;

  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP,
    S_HOLD
  } fetch_state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        valid;
  } IFID_Pipe_t;

endpackage

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, one outstanding imem request,
// redirect handling with stale-response drop, and a one-entry hold buffer.
import pipeline_pkg::*;

module if_stage #(
  parameter int          XLEN     = 64,
  parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [31:0]     imem_rsp_data_i,
  output IFID_Pipe_t      data_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  IFID_Pipe_t      hold_q, hold_d;

  logic [XLEN-1:0] tgt_pc;
  logic [XLEN-1:0] seq_pc;

  assign tgt_pc = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign seq_pc = pc_q + XLEN'(4);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    unique case (state_q)
      S_REQ: begin
        if (redirect_i) begin
          pc_d = tgt_pc;
          if (imem_req_ready_i) state_d = S_DROP;
        end else if (imem_req_ready_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_i) begin
          pc_d    = tgt_pc;
          state_d = imem_rsp_valid_i ? S_REQ : S_DROP;
        end else if (imem_rsp_valid_i) begin
          pc_d = seq_pc;
          if (stall_i) begin
            hold_d  = '{pc: pc_q, instr: imem_rsp_data_i, valid: 1'b1};
            state_d = S_HOLD;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_HOLD: begin
        if (redirect_i) begin
          pc_d    = tgt_pc;
          state_d = S_REQ;
        end else if (!stall_i) begin
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (redirect_i) pc_d = tgt_pc;
        if (imem_rsp_valid_i) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
    end
  end

  assign imem_req_valid_o = !rst_i && (state_q == S_REQ);
  assign imem_req_addr_o  = pc_q;

  // Response is forwarded the same cycle so IF/ID captures it at this edge.
  always_comb begin
    data_o = '{pc: pc_q, instr: NOP_INSTR, valid: 1'b0};
    if (rst_i) begin
      data_o = '{pc: RESET_PC, instr: NOP_INSTR, valid: 1'b0};
    end else if (state_q == S_WAIT && imem_rsp_valid_i && !redirect_i) begin
      data_o = '{pc: pc_q, instr: imem_rsp_data_i, valid: 1'b1};
    end else if (state_q == S_HOLD && !redirect_i) begin
      data_o       = hold_q;
      data_o.valid = 1'b1;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus random
// traffic against a transaction-level fetch model and a memory model.
module tb_if_stage;
  import pipeline_pkg::*;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [63:0] redirect_pc_i = '0;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i = 1'b0;
  logic [63:0] imem_req_addr_o;
  logic        imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_data_i = '0;
  IFID_Pipe_t  data_o;

  int total = 0;
  int bad = 0;

  always #5 clk_i = ~clk_i;

  if_stage #(.XLEN(64), .RESET_PC(RST_PC)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .stall_i          (stall_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .data_o           (data_o)
  );

  // Fetch model: a pending request, one in-flight access that
  // may be stale, and at most one held instruction.
  logic [63:0] m_pc;
  bit          m_issue;
  bit          m_fly;
  bit          m_stale;
  bit          m_held;
  logic [63:0] h_pc;
  logic [31:0] h_ins;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit st, input bit rd,
                      input logic [63:0] rp, input bit rdy,
                      input bit rv, input logic [31:0] rdat);
    logic [63:0] tgt;
    logic [96:0] exp_d;
    bit          exp_v;
    @(negedge clk_i);
    rst_i            = r;
    stall_i          = st;
    redirect_i       = rd;
    redirect_pc_i    = rp;
    imem_req_ready_i = rdy;
    imem_rsp_valid_i = rv;
    imem_rsp_data_i  = rdat;
    #1;
    tgt = rp & ~64'h3;
    if (r) begin
      exp_v = 1'b0;
      exp_d = {RST_PC, NOP_INSTR, 1'b0};
    end else begin
      exp_v = m_issue;
      exp_d = {m_pc, NOP_INSTR, 1'b0};
      if (m_fly && !m_stale && rv && !rd)
        exp_d = {m_pc, rdat, 1'b1};
      else if (m_held && !rd)
        exp_d = {h_pc, h_ins, 1'b1};
    end
    chk("req_valid", imem_req_valid_o, exp_v);
    if (!r) chk("req_addr", imem_req_addr_o, m_pc);
    chk("data_o", data_o, exp_d);
    @(posedge clk_i);
    if (r) begin
      m_pc = RST_PC; m_issue = 1; m_fly = 0;
      m_stale = 0; m_held = 0;
    end else if (m_issue) begin
      if (rdy) begin
        m_issue = 0; m_fly = 1; m_stale = rd;
      end
      if (rd) m_pc = tgt;
    end else if (m_fly) begin
      if (rv) begin
        m_fly = 0;
        if (m_stale || rd) begin
          m_stale = 0; m_issue = 1;
          if (rd) m_pc = tgt;
        end else begin
          if (st) begin
            m_held = 1; h_pc = m_pc; h_ins = rdat;
          end else begin
            m_issue = 1;
          end
          m_pc = m_pc + 64'd4;
        end
      end else if (rd) begin
        m_stale = 1; m_pc = tgt;
      end
    end else if (m_held) begin
      if (rd) begin
        m_held = 0; m_issue = 1; m_pc = tgt;
      end else if (!st) begin
        m_held = 0; m_issue = 1;
      end
    end
    #1;
  endtask

  initial begin
    bit          r, st, rd, rdy, rv, acc, mb;
    logic [63:0] rp, pa, ma;
    logic [31:0] rdat;
    int          mc;
    m_pc = '0; m_issue = 0; m_fly = 0; m_stale = 0; m_held = 0;
    h_pc = '0; h_ins = '0;

    // reset then streaming fetch, 1-cycle latency
    step(1, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 1, 1, 32'h1111_1111);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 1, 32'h0010_0093 + k);
    end
    chk("stream_addr", imem_req_addr_o, 64'h8000_000C);

    // stalled response held for 3 cycles
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1, 1, 32'h00A0_0093);
    step(0, 1, 0, 0, 1, 0, 0);
    chk("hold_data", data_o, {64'h8000_0000, 32'h00A0_0093, 1'b1});
    step(0, 1, 0, 0, 1, 0, 0);
    chk("hold_noreq", imem_req_valid_o, 1'b0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("hold_next", imem_req_addr_o, 64'h8000_0004);
    chk("hold_reqv", imem_req_valid_o, 1'b1);

    // redirect in WAIT without response, late response dropped
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 64'h8000_0100, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    chk("drop_addr", imem_req_addr_o, 64'h8000_0100);

    // redirect coincident with response
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 64'h8000_0180, 0, 1, 32'h1234_5678);
    chk("coinc_addr", imem_req_addr_o, 64'h8000_0180);

    // redirect retargets an unaccepted request
    step(0, 0, 1, 64'h8000_0200, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'h0000_0533);
    chk("retarget_next", imem_req_addr_o, 64'h8000_0204);

    // reset in WAIT, response arrives after reset
    step(0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'hCAFE_F00D);
    chk("rst_reissue", imem_req_addr_o, 64'h8000_0000);

    // PC wrap, with low target bits ignored
    step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'h0000_0013);
    chk("wrap_addr", imem_req_addr_o, 64'h0);

    // random traffic with a variable-latency memory
    step(1, 0, 0, 0, 0, 0, 0);
    mb = 0; mc = 0; ma = '0;
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(63) == 0);
      st  = ($urandom_range(2) == 0);
      rd  = ($urandom_range(7) == 0);
      rp  = {$urandom, $urandom};
      rdy = ($urandom_range(1) == 1);
      rdat = $urandom;
      rv  = 0;
      if (mb && mc == 0) begin
        rv = 1;
        rdat = ma[31:0] ^ ma[63:32] ^ 32'h5A5A_0000;
      end else if (!mb && $urandom_range(7) == 0) begin
        rv = 1;
      end
      acc = !r && m_issue && rdy;
      pa  = m_pc;
      step(r, st, rd, rp, rdy, rv, rdat);
      if (r) mb = 0;
      else if (mb && rv) mb = 0;
      else if (mb) mc--;
      if (acc) begin
        mb = 1; mc = $urandom_range(2); ma = pa;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage for the RV64I pipeline.
- Owns the PC, issues one instruction-memory request at a time, and presents the fetched instruction as an IFID_Pipe_t to the IF/ID pipeline register.
- Handles redirects (taken branch, jump, trap) from EX, including discarding a stale in-flight response.
- Holds a fetched instruction while the pipeline is stalled.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset.
- XLEN, 64, PC/address width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- stall_i  in  1  IF/ID stalled this cycle; data_o is not consumed
- redirect_i  in  1  control-flow redirect from EX; same signal flushes IF/ID
- redirect_pc_i  in  XLEN  redirect target; bits [1:0] ignored (treated as 0)
- imem_req_valid_o  out  1  fetch request valid
- imem_req_ready_i  in  1  memory accepts request
- imem_req_addr_o  out  XLEN  fetch address = pc_q
- imem_rsp_valid_i  in  1  response valid (earliest: cycle after acceptance)
- imem_rsp_data_i  in  32  fetched instruction word
- data_o  out  IFID_Pipe_t  {pc, instr, valid} to the IF/ID register

Behaviour:
- Registers: pc_q (bits [1:0] always 0), state_q, hold_q (IFID_Pipe_t).
- FSM states:
  - S_REQ: request issued, awaiting accept.
  - S_WAIT: accepted, awaiting response.
  - S_DROP: accepted request is stale, awaiting its response to discard.
  - S_HOLD: instruction fetched but not yet consumed.
- Reset (rst_i=1 at edge): state_q=S_REQ, pc_q=RESET_PC, hold_q='0.
  - While rst_i=1, imem_req_valid_o=0 and data_o={pc:RESET_PC, instr:NOP, valid:0}.
  - Reset mid-transaction abandons any outstanding request; the memory side is reset by the same rst_i.
- imem_req_valid_o=1 only in S_REQ; imem_req_addr_o=pc_q.
  - Address is stable while valid&&!ready, except on a redirect, which may retarget an unaccepted request.
- data_o is combinational:
  - S_WAIT with rsp_valid and !redirect_i: {pc_q, imem_rsp_data_i, 1}. Zero added latency; IF/ID captures at the same edge.
  - S_HOLD with !redirect_i: hold_q with valid=1.
  - Otherwise: bubble {pc_q, NOP=32'h0000_0013, 0}.
- S_REQ transitions:
  - redirect_i && ready: pc_q<=redirect_pc_i; go S_DROP.
  - redirect_i && !ready: pc_q<=redirect_pc_i; stay S_REQ.
  - ready: go S_WAIT.
  - stall_i does not block issue (one-deep prefetch).
- S_WAIT transitions:
  - redirect_i && rsp_valid: discard response; pc_q<=redirect_pc_i; go S_REQ.
  - redirect_i && !rsp_valid: pc_q<=redirect_pc_i; go S_DROP.
  - rsp_valid && !stall_i: pc_q<=pc_q+4; go S_REQ.
  - rsp_valid && stall_i: hold_q<={pc_q, rsp_data, 1}; pc_q<=pc_q+4; go S_HOLD.
- S_HOLD transitions:
  - redirect_i: pc_q<=redirect_pc_i; go S_REQ; hold_q discarded.
  - !stall_i: consumed this edge; go S_REQ.
  - else: stay S_HOLD.
- S_DROP transitions:
  - rsp_valid: discard; go S_REQ.
  - redirect_i (with or without rsp_valid): pc_q<=redirect_pc_i (latest redirect wins).
- Ignored inputs: imem_rsp_valid_i in S_REQ/S_HOLD; imem_req_ready_i outside S_REQ.
- pc_q+4 wraps modulo 2^64 (FFFF_FFFF_FFFF_FFFC -> 0); no exception raised.
- Throughput: at most one instruction per 2 cycles (REQ, then WAIT).
- Priority: rst_i > redirect_i > response/stall.

Decomposition:
- pipeline_pkg:
  - IFID_Pipe_t fields: pc[63:0], instr[31:0], valid.
  - NOP_INSTR = 32'h0000_0013.
  - fetch_state_e {S_REQ, S_WAIT, S_DROP, S_HOLD}.
  - RESET_PC default constant.
- No sub-module; FSM, PC and hold buffer live in one module (~150-220 lines).

Test Plan:
- Reset, then ready=1 and 1-cycle response latency:
  - Requests at 8000_0000, 8000_0004, 8000_0008.
  - data_o.valid pulses every 2nd cycle with matching pc/instr.
  - No valid output during reset.
- Response 0x00A00093 arrives with stall_i=1 for 3 cycles:
  - State S_HOLD; data_o={8000_0000, 00A00093, 1} stable all 3 cycles.
  - Next request at 8000_0004 only after stall drops.
- redirect_i=1, redirect_pc_i=8000_0100 in S_WAIT with no response:
  - S_DROP; late response 0xDEADBEEF never appears valid on data_o.
  - Next request addr 8000_0100.
- redirect_i coincident with rsp_valid in S_WAIT:
  - data_o.valid=0 that cycle; next request addr = redirect target.
- redirect_i in S_REQ with ready=0 (target 8000_0200), then ready=1:
  - Accepted addr 8000_0200; no S_DROP entry.
- rst_i asserted in S_WAIT, then a response arrives the cycle after reset:
  - Response ignored; request reissued at 8000_0000.
- pc_q=FFFF_FFFF_FFFF_FFFC fetch completes:
  - Next request addr 0000_0000_0000_0000.
